// File: rtl/proc_spawn_port.sv
// Per-processor task-dispatch endpoint: launches the core on dispatcher starts,
// buffers core spawn requests and hands them to the dispatcher one at a time.
module proc_spawn_port #(
  parameter int ADDR_W      = 8,
  parameter int SPAWN_DEPTH = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              disp_start,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              proc_busy,
  output logic              proc_onspawn,
  output logic [ADDR_W-1:0] proc_spawn_addr,
  input  logic              disp_spawn_ack,
  output logic              core_run,
  output logic [ADDR_W-1:0] core_entry,
  input  logic              core_halt,
  input  logic              core_spawn_valid,
  input  logic [ADDR_W-1:0] core_spawn_addr,
  output logic              core_spawn_ready,
  output logic [CNT_W-1:0]  spawn_total,
  output logic              protocol_error
);

  localparam int AW = $clog2(SPAWN_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mem [SPAWN_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic              full, empty, push, pop, empty_nxt;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});

  assign core_spawn_ready = (state == RUN) && !full;
  assign proc_onspawn     = !empty;
  assign proc_busy        = (state != IDLE);
  assign core_run         = (state == RUN);
  assign proc_spawn_addr  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign push      = core_spawn_valid && core_spawn_ready;
  assign pop       = disp_spawn_ack && proc_onspawn;
  assign wr_nxt    = push ? wr_ptr + PW'(1) : wr_ptr;
  assign rd_nxt    = pop  ? rd_ptr + PW'(1) : rd_ptr;
  assign empty_nxt = (wr_nxt == rd_nxt);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (disp_start) state_nxt = RUN;
      RUN:     if (core_halt)  state_nxt = empty_nxt ? IDLE : DRAIN;
      DRAIN:   if (empty_nxt)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage carries no reset; the head is masked while the buffer is empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= core_spawn_addr;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      core_entry     <= '0;
      spawn_total    <= '0;
      protocol_error <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (state == IDLE && disp_start) core_entry <= disp_addr;
      if (pop) spawn_total <= spawn_total + CNT_W'(1);
      if ((disp_start && state != IDLE) ||
          (disp_spawn_ack && empty) ||
          (core_halt && state != RUN))
        protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_spawn_port.sv
// Directed bench for proc_spawn_port: task launch, spawn handoff, drain,
// simultaneous events, protocol errors and mid-task reset.
module tb_proc_spawn_port;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        disp_start;
  logic [7:0]  disp_addr;
  logic        proc_busy, proc_onspawn;
  logic [7:0]  proc_spawn_addr;
  logic        disp_spawn_ack;
  logic        core_run;
  logic [7:0]  core_entry;
  logic        core_halt, core_spawn_valid;
  logic [7:0]  core_spawn_addr;
  logic        core_spawn_ready;
  logic [15:0] spawn_total;
  logic        protocol_error;

  int checks = 0;
  int errors = 0;

  proc_spawn_port #(.ADDR_W(8), .SPAWN_DEPTH(4), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .disp_start(disp_start), .disp_addr(disp_addr),
    .proc_busy(proc_busy), .proc_onspawn(proc_onspawn),
    .proc_spawn_addr(proc_spawn_addr), .disp_spawn_ack(disp_spawn_ack),
    .core_run(core_run), .core_entry(core_entry), .core_halt(core_halt),
    .core_spawn_valid(core_spawn_valid), .core_spawn_addr(core_spawn_addr),
    .core_spawn_ready(core_spawn_ready), .spawn_total(spawn_total),
    .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; disp_start = 0; disp_addr = 0; disp_spawn_ack = 0;
    core_halt = 0; core_spawn_valid = 0; core_spawn_addr = 0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic start_task(input logic [7:0] a);
    disp_start = 1; disp_addr = a; tick(); disp_start = 0; disp_addr = 0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL %s core_run: got %0b want 0", tag, core_run); end
    checks++; if (core_entry !== 8'h00) begin errors++; $display("FAIL %s core_entry: got %h want 00", tag, core_entry); end
    checks++; if (proc_busy !== 1'b0) begin errors++; $display("FAIL %s proc_busy: got %0b want 0", tag, proc_busy); end
    checks++; if (proc_onspawn !== 1'b0) begin errors++; $display("FAIL %s proc_onspawn: got %0b want 0", tag, proc_onspawn); end
    checks++; if (proc_spawn_addr !== 8'h00) begin errors++; $display("FAIL %s proc_spawn_addr: got %h want 00", tag, proc_spawn_addr); end
    checks++; if (core_spawn_ready !== 1'b0) begin errors++; $display("FAIL %s core_spawn_ready: got %0b want 0", tag, core_spawn_ready); end
    checks++; if (spawn_total !== 16'd0) begin errors++; $display("FAIL %s spawn_total: got %0d want 0", tag, spawn_total); end
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL %s protocol_error: got %0b want 0", tag, protocol_error); end
  endtask

  task automatic test_reset;
    do_reset();
    check_all_zero("reset");
  endtask

  task automatic basic_run(input logic [7:0] a, input logic [15:0] tot, input string tag);
    start_task(a);
    checks++; if (core_run !== 1'b1) begin errors++; $display("FAIL %s start core_run: got %0b want 1", tag, core_run); end
    checks++; if (core_entry !== a) begin errors++; $display("FAIL %s start core_entry: got %h want %h", tag, core_entry, a); end
    checks++; if (proc_busy !== 1'b1) begin errors++; $display("FAIL %s start proc_busy: got %0b want 1", tag, proc_busy); end
    checks++; if (core_spawn_ready !== 1'b1) begin errors++; $display("FAIL %s start ready: got %0b want 1", tag, core_spawn_ready); end
    repeat (4) tick();
    core_halt = 1; tick(); core_halt = 0;
    checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL %s halt core_run: got %0b want 0", tag, core_run); end
    checks++; if (proc_busy !== 1'b0) begin errors++; $display("FAIL %s halt proc_busy: got %0b want 0", tag, proc_busy); end
    checks++; if (spawn_total !== tot) begin errors++; $display("FAIL %s halt spawn_total: got %0d want %0d", tag, spawn_total, tot); end
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL %s protocol_error: got %0b want 0", tag, protocol_error); end
  endtask

  task automatic test_basic;
    basic_run(8'h12, 16'd0, "basic");
  endtask

  task automatic test_spawn;
    start_task(8'h05);
    for (int i = 0; i < 3; i++) begin
      core_spawn_valid = 1; core_spawn_addr = 8'h20 + 8'(i); tick();
      if (i == 0) begin
        checks++; if (proc_onspawn !== 1'b1 || proc_spawn_addr !== 8'h20) begin errors++; $display("FAIL spawn_first: got onspawn=%0b addr=%h want 1/20", proc_onspawn, proc_spawn_addr); end
      end
    end
    core_spawn_valid = 0; core_spawn_addr = 0;
    disp_spawn_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (spawn_total !== 16'(i + 1)) begin errors++; $display("FAIL spawn_total_%0d: got %0d want %0d", i, spawn_total, i + 1); end
      if (i < 2) begin
        checks++; if (proc_spawn_addr !== 8'h21 + 8'(i)) begin errors++; $display("FAIL spawn_order_%0d: got %h want %h", i, proc_spawn_addr, 8'h21 + 8'(i)); end
      end
    end
    disp_spawn_ack = 0;
    checks++; if (proc_onspawn !== 1'b0) begin errors++; $display("FAIL spawn_drained: got %0b want 0", proc_onspawn); end
    core_halt = 1; tick(); core_halt = 0;
    checks++; if (proc_busy !== 1'b0) begin errors++; $display("FAIL spawn_idle: got busy=%0b want 0", proc_busy); end
  endtask

  task automatic test_full_drain;
    start_task(8'h07);
    for (int i = 0; i < 4; i++) begin
      core_spawn_valid = 1; core_spawn_addr = 8'h50 + 8'(i); tick();
    end
    checks++; if (core_spawn_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", core_spawn_ready); end
    core_spawn_valid = 0; core_spawn_addr = 0;
    core_halt = 1; tick(); core_halt = 0;
    checks++; if (proc_busy !== 1'b1 || core_run !== 1'b0) begin errors++; $display("FAIL drain_state: got busy=%0b run=%0b want 1/0", proc_busy, core_run); end
    checks++; if (proc_spawn_addr !== 8'h50) begin errors++; $display("FAIL drain_head: got %h want 50", proc_spawn_addr); end
    disp_spawn_ack = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) begin
        checks++; if (proc_busy !== 1'b1) begin errors++; $display("FAIL drain_busy_%0d: got %0b want 1", i, proc_busy); end
      end
    end
    disp_spawn_ack = 0;
    checks++; if (proc_busy !== 1'b0) begin errors++; $display("FAIL drain_idle: got %0b want 0", proc_busy); end
    checks++; if (spawn_total !== 16'd7) begin errors++; $display("FAIL drain_total: got %0d want 7", spawn_total); end
  endtask

  task automatic test_simultaneous;
    start_task(8'h08);
    core_spawn_valid = 1;
    core_spawn_addr = 8'h60; tick();
    core_spawn_addr = 8'h61; tick();
    core_spawn_addr = 8'h62; disp_spawn_ack = 1; tick();
    core_spawn_valid = 0; core_spawn_addr = 0;
    checks++; if (proc_spawn_addr !== 8'h61 || spawn_total !== 16'd8) begin errors++; $display("FAIL pushpop_head: got %h/%0d want 61/8", proc_spawn_addr, spawn_total); end
    tick();
    checks++; if (proc_onspawn !== 1'b1 || proc_spawn_addr !== 8'h62) begin errors++; $display("FAIL pushpop_occ: got onspawn=%0b addr=%h want 1/62", proc_onspawn, proc_spawn_addr); end
    tick();
    disp_spawn_ack = 0;
    checks++; if (proc_onspawn !== 1'b0 || spawn_total !== 16'd10) begin errors++; $display("FAIL pushpop_empty: got onspawn=%0b total=%0d want 0/10", proc_onspawn, spawn_total); end
    core_halt = 1; core_spawn_valid = 1; core_spawn_addr = 8'h30; tick();
    core_halt = 0; core_spawn_valid = 0; core_spawn_addr = 0;
    checks++; if (proc_busy !== 1'b1 || core_run !== 1'b0 || core_spawn_ready !== 1'b0) begin errors++; $display("FAIL halt_push_drain: got busy=%0b run=%0b rdy=%0b want 1/0/0", proc_busy, core_run, core_spawn_ready); end
    checks++; if (proc_onspawn !== 1'b1 || proc_spawn_addr !== 8'h30) begin errors++; $display("FAIL halt_push_head: got %0b/%h want 1/30", proc_onspawn, proc_spawn_addr); end
    disp_spawn_ack = 1; tick(); disp_spawn_ack = 0;
    checks++; if (proc_busy !== 1'b0 || spawn_total !== 16'd11) begin errors++; $display("FAIL halt_push_idle: got busy=%0b total=%0d want 0/11", proc_busy, spawn_total); end
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL simul_err: got %0b want 0", protocol_error); end
  endtask

  task automatic test_errors;
    core_halt = 1; tick(); core_halt = 0;
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL err_halt_idle: got %0b want 1", protocol_error); end
    checks++; if (core_entry !== 8'h08 || spawn_total !== 16'd11 || proc_busy !== 1'b0) begin errors++; $display("FAIL err_halt_side: got entry=%h total=%0d busy=%0b want 08/11/0", core_entry, spawn_total, proc_busy); end
    do_reset();
    start_task(8'h21);
    disp_spawn_ack = 1; tick(); disp_spawn_ack = 0;
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL err_ack_empty: got %0b want 1", protocol_error); end
    checks++; if (spawn_total !== 16'd0 || core_entry !== 8'h21 || core_run !== 1'b1) begin errors++; $display("FAIL err_ack_side: got total=%0d entry=%h run=%0b want 0/21/1", spawn_total, core_entry, core_run); end
    do_reset();
    start_task(8'h11);
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL err_clean: got %0b want 0", protocol_error); end
    start_task(8'h99);
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL err_start_busy: got %0b want 1", protocol_error); end
    checks++; if (core_entry !== 8'h11 || core_run !== 1'b1 || spawn_total !== 16'd0) begin errors++; $display("FAIL err_start_side: got entry=%h run=%0b total=%0d want 11/1/0", core_entry, core_run, spawn_total); end
    do_reset();
  endtask

  task automatic test_reset_mid;
    start_task(8'h13);
    core_spawn_valid = 1;
    core_spawn_addr = 8'h70; tick();
    core_spawn_addr = 8'h71; tick();
    core_spawn_valid = 0; core_spawn_addr = 0;
    checks++; if (proc_onspawn !== 1'b1 || proc_busy !== 1'b1) begin errors++; $display("FAIL mid_pre: got onspawn=%0b busy=%0b want 1/1", proc_onspawn, proc_busy); end
    do_reset();
    check_all_zero("mid_reset");
    basic_run(8'h40, 16'd0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spawn();
    test_full_drain();
    test_simultaneous();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_spawn_port.md
# proc_spawn_port

Per-processor endpoint of the task-dispatch protocol; one instance sits between each processor core and the central dispatcher. It accepts task starts from the dispatcher and launches the core at the given entry address. It buffers spawn requests raised by the running core and presents them one at a time to the dispatcher. It reports the processor busy until the core has halted and every buffered spawn has been handed off.

## Interface
Parameters:
- ADDR_W, 8, task entry-address width
- SPAWN_DEPTH, 4, spawn buffer entries; power of two, ≥2
- CNT_W, 16, width of spawn_total counter

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- disp_start  in  1  one-cycle pulse from the dispatcher: assign the task at disp_addr
- disp_addr  in  ADDR_W  entry address, valid with disp_start
- proc_busy  out  1  processor occupied; dispatcher issues disp_start only while low
- proc_onspawn  out  1  spawn request pending toward the dispatcher
- proc_spawn_addr  out  ADDR_W  entry address of the pending spawn (FIFO head)
- disp_spawn_ack  in  1  one-cycle pulse: dispatcher has enqueued proc_spawn_addr
- core_run  out  1  core enable
- core_entry  out  ADDR_W  start address for the core, stable while core_run is high
- core_halt  in  1  one-cycle pulse: core finished its task
- core_spawn_valid  in  1  core requests a spawn
- core_spawn_addr  in  ADDR_W  spawn entry address
- core_spawn_ready  out  1  spawn accepted when valid && ready
- spawn_total  out  CNT_W  count of acknowledged spawns, wraps
- protocol_error  out  1  sticky error flag; cleared only by reset

## Operation
- FSM states:
  - IDLE: waiting for a task.
  - RUN: core executing.
  - DRAIN: core halted, spawn buffer not yet empty.
- Transitions:
  - IDLE→RUN on disp_start: latch disp_addr into core_entry, set core_run.
  - RUN→IDLE on core_halt when, after this cycle's push/pop, the FIFO is empty. Otherwise RUN→DRAIN.
  - In both cases core_run clears at that same edge.
  - DRAIN→IDLE at the edge where the pop empties the FIFO.
- proc_busy = (state != IDLE). It is registered, so it is high from the edge after disp_start.
- Spawn FIFO:
  - SPAWN_DEPTH entries; read/write pointers carry one extra wrap bit. full = pointers equal except the MSB; empty = pointers equal.
  - Push on core_spawn_valid && core_spawn_ready. core_spawn_ready = (state==RUN) && !full.
  - Pop on disp_spawn_ack && proc_onspawn. proc_onspawn = !empty. proc_spawn_addr = head entry.
  - A push and a pop in the same cycle are both performed and occupancy is unchanged.
  - When full, ready is low, so a push-with-pop does not occur.
- A core_spawn_valid arriving in the same cycle as core_halt is still accepted (ready is evaluated in RUN) and is drained before IDLE.
- spawn_total increments on each pop and wraps modulo 2^CNT_W.
- protocol_error is set, with no other effect, on any of:
  - disp_start while proc_busy is high. The start is ignored and core_entry is unchanged.
  - disp_spawn_ack while proc_onspawn is low. No pop.
  - core_halt outside RUN. Ignored.
- Reset (reset_n low at an edge, including mid-task) sets:
  - state IDLE; FIFO emptied, pending spawns discarded;
  - core_run=0, core_entry=0, proc_busy=0, proc_onspawn=0, proc_spawn_addr=0;
  - core_spawn_ready=0, spawn_total=0, protocol_error=0.

## Timing
- All state is updated on the rising edge of clock. Outputs are registered or decoded from registers only; there are no input-to-output combinational paths except core_spawn_ready, which has none (it decodes state and full).
- Start latency: disp_start sampled at edge N → core_run=1, core_entry valid, proc_busy=1 after edge N.
- Spawn latency: push at edge N → proc_onspawn=1 with that address after edge N, provided the FIFO was empty.
- Pop at edge N → the next entry is presented after edge N. Back-to-back acks drain one entry per cycle.
- Halt with empty FIFO at edge N → proc_busy=0 after edge N. The dispatcher may issue disp_start in cycle N+1.
- Last pop in DRAIN at edge N → proc_busy=0 after edge N.

## Test plan
- Basic task, no spawns:
  - disp_start with disp_addr=0x12 → next cycle core_run=1, core_entry=0x12, proc_busy=1.
  - core_halt 5 cycles later → next cycle core_run=0, proc_busy=0, spawn_total=0.
- Spawn handoff:
  - Core pushes 0x20, 0x21, 0x22 on consecutive cycles → proc_onspawn=1, addresses presented in order.
  - Acks on 3 consecutive cycles → spawn_total=3 and proc_onspawn=0 after the third ack.
- Full buffer and halt/drain:
  - With SPAWN_DEPTH=4, push 4 entries with no ack → core_spawn_ready=0.
  - core_halt → state DRAIN, proc_busy stays 1.
  - 4 acks → proc_busy=0 on the edge of the 4th ack.
- Simultaneous events:
  - Push and ack in the same cycle with 2 entries buffered → occupancy stays 2.
  - core_halt together with core_spawn_valid (addr 0x30) → 0x30 accepted, DRAIN entered, 0x30 presented, IDLE after its ack.
- Protocol errors: each of the following → protocol_error=1, with core_entry and spawn_total unchanged:
  - disp_start while busy;
  - ack while proc_onspawn=0;
  - core_halt in IDLE.
- Reset mid-task:
  - reset_n low for one edge during RUN with 2 buffered spawns → every output 0.
  - A following disp_start 0x40 behaves as the basic-task scenario.
